// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with stall/flush control and ready/valid handshake.
// Define PIPE_SKID_REG_SKID_EN to add a skid entry and register in_ready away from out_ready.
module pipe_skid_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_q,   main_d;
  logic              in_xfer,  out_xfer;

  assign out_xfer  = main_v_q && out_ready && !stall;
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

`ifdef PIPE_SKID_REG_SKID_EN
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_q,   skid_d;

  // Only the registered skid flag gates acceptance, so out_ready never reaches in_ready.
  assign in_ready  = !skid_v_q && !stall && !flush;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      main_d   = FLUSH_VAL;
      skid_v_d = 1'b0;
      skid_d   = FLUSH_VAL;
    end else if (skid_v_q) begin
      if (out_xfer) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
        skid_d   = FLUSH_VAL;
      end
    end else if (main_v_q) begin
      if (in_xfer && out_xfer) begin
        main_d = in_data;
      end else if (in_xfer) begin
        skid_v_d = 1'b1;
        skid_d   = in_data;
      end else if (out_xfer) begin
        main_v_d = 1'b0;
        main_d   = FLUSH_VAL;
      end
    end else if (in_xfer) begin
      main_v_d = 1'b1;
      main_d   = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_v_q <= 1'b0;
      skid_q   <= FLUSH_VAL;
    end else begin
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
    end
  end
`else
  assign in_ready  = (!main_v_q || out_ready) && !stall && !flush;
  assign occupancy = {1'b0, main_v_q};

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    if (flush) begin
      main_v_d = 1'b0;
      main_d   = FLUSH_VAL;
    end else if (in_xfer) begin
      main_v_d = 1'b1;
      main_d   = in_data;
    end else if (out_xfer) begin
      // Drained entry reverts to the bubble value so no stale payload is visible.
      main_v_d = 1'b0;
      main_d   = FLUSH_VAL;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      main_q   <= FLUSH_VAL;
    end else begin
      main_v_q <= main_v_d;
      main_q   <= main_d;
    end
  end

endmodule
